// File: rtl/axi_stream_ring_writer.sv
// -----------------------------------------------------------------------------
// axi_stream_ring_writer
//
// AXI4 write master that moves an AXI-Stream into a DDR ring buffer. Data is
// written as fixed-length INCR bursts. The burst address wraps back to BASE_ADDR
// at the end of the ring. A burst cut short by tlast is filled out with
// zero-strobe beats. Bursts that have no B response yet are counted and capped
// at MAX_OUTSTANDING.
//
// Optional feature macro: AXI_WR_BRESP_CHECK_EN
//   defined   : a non-OKAY bresp sets sticky err. The current burst finishes,
//               then the FSM parks in HALT until reset.
//   undefined : bresp is ignored, err is tied low, and HALT is never entered.
//
// Ports
//   aclk, areset      clock, asynchronous active-high reset
//   enable            level; new bursts start only while high
//   s_axis_*          stream input (tdata/tvalid/tready/tlast)
//   m_axi_aw*         write address channel (constant fields tied off)
//   m_axi_w*          write data channel
//   m_axi_b*          write response channel (bid ignored)
//   next_addr         address the next burst will use
//   bursts_done       count of B responses received (wraps)
//   frame_done        pulse on the final beat of a burst that held tlast
//   busy              FSM not idle, or bursts still awaiting B
//   err               sticky bresp error (only with the macro)
// -----------------------------------------------------------------------------
module axi_stream_ring_writer #(
  parameter int unsigned            ADDR_WIDTH      = 32,
  parameter int unsigned            DATA_WIDTH      = 64,
  parameter int unsigned            BURST_LEN       = 16,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR       = 32'h2000_0000,
  parameter logic [ADDR_WIDTH-1:0]  RING_BYTES      = 32'h0010_0000,
  parameter int unsigned            MAX_OUTSTANDING = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    enable,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic                    m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic                    m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   next_addr,
  output logic [31:0]             bursts_done,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned           STRB_WIDTH  = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] RING_END    = BASE_ADDR + RING_BYTES;
  localparam logic [8:0]            LAST_BEAT   = 9'(BURST_LEN - 1);
  localparam logic [3:0]            MAX_OUT     = 4'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, PAD, HALT} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [ADDR_WIDTH-1:0] r_nextAddr;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic                  r_awvalid;
  logic [8:0]            r_beatCnt;
  logic [3:0]            r_outstanding;
  logic [31:0]           r_burstsDone;
  logic                  r_bready;
  logic                  w_err;
  logic                  w_awHs;
  logic                  w_wHs;
  logic                  w_bHs;
  logic                  w_wlast;
  logic                  w_canStart;
  logic [ADDR_WIDTH-1:0] w_addrInc;
  logic                  w_unused;

  // Handshake strobes and burst-position helpers shared by every process below
  assign w_awHs     = r_awvalid & m_axi_awready;
  assign w_wHs      = m_axi_wvalid & m_axi_wready;
  assign w_bHs      = m_axi_bvalid & r_bready;
  assign w_wlast    = (r_beatCnt == LAST_BEAT);
  assign w_canStart = enable & s_axis_tvalid & (r_outstanding < MAX_OUT) & ~w_err;
  assign w_addrInc  = r_nextAddr + BURST_BYTES;

`ifdef AXI_WR_BRESP_CHECK_EN
  logic r_err;

  // Any non-OKAY response latches the error until reset. The FSM reads it only
  // in IDLE, so a burst already in flight always runs to completion.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_err <= 1'b0;
    end else if (w_bHs && (m_axi_bresp != 2'b00)) begin
      r_err <= 1'b1;
    end
  end

  assign w_err    = r_err;
  assign w_unused = m_axi_bid;
`else
  assign w_err    = 1'b0;
  assign w_unused = ^{m_axi_bid, m_axi_bresp};
`endif

  // State register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A burst only ever ends back in IDLE, which is where
  // enable, the outstanding limit and the error flag are looked at again.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_err) begin
          w_nextState = HALT;
        end else if (w_canStart) begin
          w_nextState = ADDR;
        end
      end
      ADDR: begin
        if (w_awHs) begin
          w_nextState = DATA;
        end
      end
      DATA: begin
        if (w_wHs) begin
          if (w_wlast) begin
            w_nextState = IDLE;
          end else if (s_axis_tlast) begin
            w_nextState = PAD;
          end
        end
      end
      PAD: begin
        if (w_wHs && w_wlast) begin
          w_nextState = IDLE;
        end
      end
      HALT:    w_nextState = HALT;
      default: w_nextState = IDLE;
    endcase
  end

  // W-channel outputs. DATA is a pure pass-through from the stream. PAD drives
  // zero-strobe filler beats while holding the stream off.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wdata   = '0;
    m_axi_wstrb   = '0;
    m_axi_wlast   = 1'b0;
    frame_done    = 1'b0;
    case (r_state)
      DATA: begin
        s_axis_tready = m_axi_wready;
        m_axi_wvalid  = s_axis_tvalid;
        m_axi_wdata   = s_axis_tdata;
        m_axi_wstrb   = '1;
        m_axi_wlast   = w_wlast;
        frame_done    = s_axis_tvalid & m_axi_wready & s_axis_tlast & w_wlast;
      end
      PAD: begin
        m_axi_wvalid  = 1'b1;
        m_axi_wlast   = w_wlast;
        frame_done    = m_axi_wready & w_wlast;
      end
      default: ;
    endcase
  end

  // AW request. The address is captured on entry to ADDR and then held steady
  // until the slave accepts it.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_awvalid <= 1'b0;
      r_awaddr  <= '0;
    end else if ((r_state == IDLE) && (w_nextState == ADDR)) begin
      r_awvalid <= 1'b1;
      r_awaddr  <= r_nextAddr;
    end else if (w_awHs) begin
      r_awvalid <= 1'b0;
    end
  end

  // Ring pointer. It advances only once a burst is committed on AW, and folds
  // back to the base when it reaches the end of the ring.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_nextAddr <= BASE_ADDR;
    end else if (w_awHs) begin
      r_nextAddr <= (w_addrInc == RING_END) ? BASE_ADDR : w_addrInc;
    end
  end

  // Beat position within the current burst. Filler beats count the same as
  // real ones.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_beatCnt <= '0;
    end else if (w_wHs) begin
      r_beatCnt <= w_wlast ? 9'd0 : r_beatCnt + 9'd1;
    end
  end

  // B-channel bookkeeping. If an AW accept and a B response land in the same
  // cycle, they cancel and the outstanding count is unchanged.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_bready      <= 1'b0;
      r_outstanding <= '0;
      r_burstsDone  <= '0;
    end else begin
      r_bready <= 1'b1;
      case ({w_awHs, w_bHs})
        2'b10:   r_outstanding <= r_outstanding + 4'd1;
        2'b01:   r_outstanding <= (r_outstanding != 4'd0) ? r_outstanding - 4'd1 : 4'd0;
        default: ;
      endcase
      if (w_bHs) begin
        r_burstsDone <= r_burstsDone + 32'd1;
      end
    end
  end

  assign m_axi_awid    = 1'b0;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awlen   = 8'(BURST_LEN - 1);
  assign m_axi_awsize  = 3'($clog2(STRB_WIDTH));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_bready  = r_bready;
  assign next_addr     = r_nextAddr;
  assign bursts_done   = r_burstsDone;
  assign busy          = (r_state != IDLE) | (r_outstanding != 4'd0);
  assign err           = w_err;

endmodule

// File: tb/tb_axi_stream_ring_writer.sv
// -----------------------------------------------------------------------------
// tb_axi_stream_ring_writer
//
// Scoreboard bench for axi_stream_ring_writer. The stimulus tasks turn every
// stream beat into the AW addresses and W beats the ring writer should produce,
// using a simple beats-into-bursts model of the ring. A monitor process pops
// and compares those expectations whenever the DUT handshakes on AW or W. A
// B responder returns write responses, which the bench can hold back or mark
// as errors. The bench follows AXI_WR_BRESP_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_stream_ring_writer;

  localparam int          DW          = 64;
  localparam int          BL          = 16;
  localparam logic [31:0] BASE        = 32'h2000_0000;
  localparam logic [31:0] RING        = 32'h0000_0400;
  localparam logic [31:0] BURST_BYTES = 32'h80;
  localparam int          BUDGET      = 300;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          enable = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic          m_axi_awid;
  logic [31:0]   m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic          m_axi_awlock;
  logic [3:0]    m_axi_awcache;
  logic [2:0]    m_axi_awprot;
  logic [3:0]    m_axi_awqos;
  logic          m_axi_awvalid;
  logic          m_axi_awready = 1'b1;
  logic [DW-1:0] m_axi_wdata;
  logic [7:0]    m_axi_wstrb;
  logic          m_axi_wlast;
  logic          m_axi_wvalid;
  logic          m_axi_wready = 1'b1;
  logic          m_axi_bid = 1'b0;
  logic [1:0]    m_axi_bresp = 2'b00;
  logic          m_axi_bvalid = 1'b0;
  logic          m_axi_bready;
  logic [31:0]   next_addr;
  logic [31:0]   bursts_done;
  logic          frame_done;
  logic          busy;
  logic          err;

  axi_stream_ring_writer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(DW), .BURST_LEN(BL),
    .BASE_ADDR(BASE), .RING_BYTES(RING), .MAX_OUTSTANDING(4)
  ) dut (
    .aclk(aclk), .areset(areset), .enable(enable),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .next_addr(next_addr), .bursts_done(bursts_done), .frame_done(frame_done),
    .busy(busy), .err(err)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0] data;
    logic [7:0]    strb;
    logic          last;
    logic          frame;
  } wBeat_t;

  wBeat_t      expW[$];
  logic [31:0] expAw[$];

  int          tests = 0;
  int          fails = 0;
  int          mPos = 0;
  logic [31:0] mAddr = BASE;
  int          expFrames = 0;
  int          awCount = 0;
  int          frameCount = 0;
  int          bCount = 0;
  int          pending = 0;
  bit          throttle = 0;
  bit          holdB = 0;
  int          bAllow = 0;
  bit          errNext = 0;

  // Every comparison in the bench goes through here
  function automatic void checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Ring model: beats fill bursts of BL. A tlast before the end of a burst is
  // followed by zero-strobe filler up to the burst boundary. Each new burst takes
  // the next ring slot.
  function automatic void modelBeat(input logic [DW-1:0] d, input logic l);
    wBeat_t b;
    if (mPos == 0) begin
      expAw.push_back(mAddr);
      mAddr = mAddr + BURST_BYTES;
      if (mAddr == BASE + RING) mAddr = BASE;
    end
    b.data = d; b.strb = 8'hFF; b.last = (mPos == BL - 1); b.frame = l && (mPos == BL - 1);
    expW.push_back(b);
    mPos++;
    if (l) begin
      expFrames++;
      while (mPos < BL) begin
        b.data = '0; b.strb = 8'h00; b.last = (mPos == BL - 1); b.frame = (mPos == BL - 1);
        expW.push_back(b);
        mPos++;
      end
    end
    if (mPos == BL) mPos = 0;
  endfunction

  // Present one stream beat, hold it until it is accepted, give up after BUDGET cycles
  task automatic applyStimulus(input logic [DW-1:0] d, input logic l);
    int  n;
    logic hs;
    modelBeat(d, l);
    if (throttle && ($urandom_range(3) == 0)) begin
      s_axis_tvalid = 1'b0;
      @(posedge aclk); #1;
    end
    s_axis_tdata = d; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    n = 0; hs = 1'b0;
    while (!hs && n < BUDGET) begin
      @(negedge aclk);
      hs = s_axis_tready;
      @(posedge aclk); #1;
      n++;
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    checkOutput("beat_accepted", hs, 1);
  endtask

  task automatic sendFrame(input int len, input bit lastAtEnd);
    for (int i = 0; i < len; i++) applyStimulus({$urandom, $urandom}, lastAtEnd && (i == len - 1));
  endtask

  task automatic waitDrain(input string name, input bit needIdle);
    int n = 0;
    while (n < 3000 && !(expW.size() == 0 && expAw.size() == 0 && pending == 0 &&
                         !m_axi_bvalid && (!needIdle || !busy))) begin
      @(negedge aclk);
      n++;
    end
    checkOutput({name, "_drained"}, n < 3000, 1);
    repeat (3) @(negedge aclk);
  endtask

  task automatic resetDut();
    areset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checkOutput("rst_next_addr", next_addr, BASE);
    checkOutput("rst_awaddr", m_axi_awaddr, 0);
    checkOutput("rst_awvalid", m_axi_awvalid, 0);
    checkOutput("rst_wvalid", m_axi_wvalid, 0);
    checkOutput("rst_tready", s_axis_tready, 0);
    checkOutput("rst_bready", m_axi_bready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_bursts_done", bursts_done, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("const_awlen", m_axi_awlen, 15);
    checkOutput("const_awsize", m_axi_awsize, 3);
    checkOutput("const_awburst", m_axi_awburst, 1);
    checkOutput("const_awcache", m_axi_awcache, 3);
    checkOutput("const_awid", m_axi_awid, 0);
    expW.delete(); expAw.delete();
    mPos = 0; mAddr = BASE; expFrames = 0;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    checkOutput("bready_after_reset", m_axi_bready, 1);
  endtask

  // Slave ready generator: always ready, or randomly throttled
  always begin
    @(posedge aclk); #1;
    m_axi_awready = throttle ? ($urandom_range(2) != 0) : 1'b1;
    m_axi_wready  = throttle ? ($urandom_range(2) != 0) : 1'b1;
  end

  // B responder: one response owed per completed burst, returned after a random
  // delay. Responses can be withheld or released one at a time.
  always begin
    logic wlHs, bHs;
    @(negedge aclk);
    wlHs = m_axi_wvalid && m_axi_wready && m_axi_wlast && !areset;
    bHs  = m_axi_bvalid && m_axi_bready && !areset;
    @(posedge aclk); #1;
    if (areset) begin
      pending = 0; bCount = 0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    end else begin
      if (wlHs) pending++;
      if (bHs) begin
        pending--; bCount++; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
      end
      if (!m_axi_bvalid && pending > 0 && (!holdB || bAllow > 0) && $urandom_range(1) == 1) begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = errNext ? 2'b10 : 2'b00;
        errNext = 0;
        if (holdB) bAllow--;
      end
    end
  end

  // Monitor: compares each AW/W handshake against the scoreboard queues, and
  // checks that a stalled request is held steady
  always begin
    bit            awWait, wWait;
    logic [31:0]   awWaitAddr;
    logic [DW-1:0] wWaitData;
    logic [7:0]    wWaitStrb;
    logic          wWaitLast;
    wBeat_t        e;
    logic [31:0]   ea;
    @(negedge aclk);
    if (areset) begin
      awCount = 0; frameCount = 0; awWait = 0; wWait = 0;
    end else begin
      if (awWait) begin
        checkOutput("aw_hold_valid", m_axi_awvalid, 1);
        checkOutput("aw_hold_addr", m_axi_awaddr, awWaitAddr);
      end
      if (wWait) begin
        checkOutput("w_hold_valid", m_axi_wvalid, 1);
        checkOutput("w_hold_data", m_axi_wdata, wWaitData);
        checkOutput("w_hold_strb", m_axi_wstrb, wWaitStrb);
        checkOutput("w_hold_last", m_axi_wlast, wWaitLast);
      end
      if (m_axi_awvalid && m_axi_awready) begin
        awCount++;
        checkOutput("aw_expected", expAw.size() != 0, 1);
        if (expAw.size() != 0) begin
          ea = expAw.pop_front();
          checkOutput("aw_addr", m_axi_awaddr, ea);
        end
      end
      if (m_axi_wvalid && m_axi_wready) begin
        checkOutput("w_expected", expW.size() != 0, 1);
        if (expW.size() != 0) begin
          e = expW.pop_front();
          checkOutput("w_data", m_axi_wdata, e.data);
          checkOutput("w_strb", m_axi_wstrb, e.strb);
          checkOutput("w_last", m_axi_wlast, e.last);
          checkOutput("frame_done", frame_done, e.frame);
        end
        if (frame_done) frameCount++;
      end else if (frame_done) begin
        checkOutput("frame_done_without_beat", frame_done, 0);
      end
      awWait = m_axi_awvalid && !m_axi_awready;
      awWaitAddr = m_axi_awaddr;
      wWait = m_axi_wvalid && !m_axi_wready;
      wWaitData = m_axi_wdata; wWaitStrb = m_axi_wstrb; wWaitLast = m_axi_wlast;
    end
  end

  // Watchdog so a stuck run still ends with a failure report
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int seenReady;
    int seenAw;
    resetDut();

    // Two full bursts ending in tlast, no throttling
    throttle = 0;
    sendFrame(32, 1);
    waitDrain("two_bursts", 1);
    checkOutput("two_bursts_bursts_done", bursts_done, 2);
    checkOutput("two_bursts_frames", frameCount, 1);
    checkOutput("two_bursts_next_addr", next_addr, 32'h2000_0100);

    // With enable low, no burst may start and no beat may be taken
    enable = 1'b0; s_axis_tdata = 64'h1234; s_axis_tvalid = 1'b1;
    seenReady = 0; seenAw = 0;
    repeat (20) begin
      @(negedge aclk);
      if (s_axis_tready) seenReady++;
      if (m_axi_awvalid) seenAw++;
    end
    checkOutput("enable_low_tready", seenReady, 0);
    checkOutput("enable_low_awvalid", seenAw, 0);
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0; enable = 1'b1;

    // Nine bursts from a fresh reset: the ninth wraps back to the base
    resetDut();
    sendFrame(9 * BL, 1);
    waitDrain("wrap", 1);
    checkOutput("wrap_next_addr", next_addr, 32'h2000_0080);
    checkOutput("wrap_bursts_done", bursts_done, 9);

    // A short frame is padded to a full burst, then a new burst follows
    throttle = 1;
    sendFrame(5, 1);
    sendFrame(BL, 1);
    waitDrain("pad", 1);
    checkOutput("pad_frames", frameCount, expFrames);
    checkOutput("pad_next_addr", next_addr, mAddr);

    // Withheld B responses: four bursts go out, the fifth waits for one response
    throttle = 0; holdB = 1; bAllow = 0; base = awCount;
    fork
      sendFrame(5 * BL, 1);
    join_none
    repeat (150) @(negedge aclk);
    checkOutput("outstanding_stall_aw", awCount - base, 4);
    checkOutput("outstanding_stall_busy", busy, 1);
    checkOutput("outstanding_stall_awvalid", m_axi_awvalid, 0);
    checkOutput("outstanding_stall_tready", s_axis_tready, 0);
    bAllow = 1;
    repeat (40) @(negedge aclk);
    checkOutput("outstanding_resume_aw", awCount - base, 5);
    holdB = 0;
    wait fork;
    waitDrain("outstanding", 1);
    checkOutput("outstanding_bursts_done", bursts_done, bCount);

    // Random frames with random throttling on all channels
    throttle = 1;
    for (int i = 0; i < 120; i++) applyStimulus({$urandom, $urandom}, $urandom_range(9) == 0);
    applyStimulus({$urandom, $urandom}, 1'b1);
    waitDrain("random", 1);
    checkOutput("random_frames", frameCount, expFrames);
    checkOutput("random_next_addr", next_addr, mAddr);
    checkOutput("random_bursts_done", bursts_done, bCount);

    // Reset in the middle of a burst, then restart from the ring base
    for (int i = 0; i < 7; i++) applyStimulus({$urandom, $urandom}, 1'b0);
    resetDut();
    sendFrame(BL, 1);
    waitDrain("after_reset", 1);
    checkOutput("after_reset_next_addr", next_addr, BASE + BURST_BYTES);
    checkOutput("after_reset_bursts_done", bursts_done, 1);

    // Error response on the next burst
    throttle = 0; errNext = 1;
    sendFrame(BL, 1);
    waitDrain("bresp_err", 0);
`ifdef AXI_WR_BRESP_CHECK_EN
    checkOutput("err_set", err, 1);
    s_axis_tdata = 64'hABCD; s_axis_tvalid = 1'b1;
    seenReady = 0; seenAw = 0;
    repeat (40) begin
      @(negedge aclk);
      if (s_axis_tready) seenReady++;
      if (m_axi_awvalid) seenAw++;
    end
    checkOutput("halt_tready", seenReady, 0);
    checkOutput("halt_awvalid", seenAw, 0);
    checkOutput("halt_busy", busy, 1);
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
`else
    checkOutput("err_ignored", err, 0);
    sendFrame(BL, 1);
    waitDrain("after_err", 1);
    checkOutput("after_err_bursts_done", bursts_done, bCount);
    checkOutput("after_err_next_addr", next_addr, mAddr);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
